// File: rtl/data_wr_ctrl_if.sv
// -----------------------------------------------------------------------------
// data_wr_ctrl_if
// Bundles the signals of the data-memory write controller.
//   Posted-write handshake : WR_REQ, WR_ADDR, WR_DATA -> controller, WR_ACK <- controller
//   Word-register commit    : WE (one-hot), WDATA      <- controller
//   Read-side hazard query  : RD_SEL -> controller, RD_HAZ <- controller
//   Status                  : BUSY, COUNT              <- controller
// slave  : controller side.
// master : requester / read-side / word-register side.
// -----------------------------------------------------------------------------
interface data_wr_ctrl_if #(
  parameter int DW    = 16,
  parameter int AW    = 4,
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic              WR_REQ;
  logic [AW-1:0]     WR_ADDR;
  logic [DW-1:0]     WR_DATA;
  logic              WR_ACK;
  logic [2**AW-1:0]  WE;
  logic [DW-1:0]     WDATA;
  logic [AW-1:0]     RD_SEL;
  logic              RD_HAZ;
  logic              BUSY;
  logic [CW-1:0]     COUNT;

  modport slave (
    input  WR_REQ, WR_ADDR, WR_DATA, RD_SEL,
    output WR_ACK, WE, WDATA, RD_HAZ, BUSY, COUNT
  );

  modport master (
    output WR_REQ, WR_ADDR, WR_DATA, RD_SEL,
    input  WR_ACK, WE, WDATA, RD_HAZ, BUSY, COUNT
  );
endinterface

// File: rtl/data_wr_ctrl.sv
// -----------------------------------------------------------------------------
// data_wr_ctrl
// Write-side controller for the 2**AW-word x DW-bit data memory.
// Posted writes are accepted over a valid/ack handshake into an in-order FIFO
// of DEPTH entries and committed one per cycle as a registered one-hot word
// enable plus data. RD_HAZ tells the read side that a write to the address it
// is selecting is still buffered or being committed.
// Ports:
//   CLK  : clock, all state on rising edge
//   RST  : synchronous reset, active-high
//   bus  : data_wr_ctrl_if.slave (handshake, commit, hazard query, status)
// -----------------------------------------------------------------------------
module data_wr_ctrl #(
  parameter int DW    = 16,
  parameter int AW    = 4,
  parameter int DEPTH = 4
) (
  input  logic          CLK,
  input  logic          RST,
  data_wr_ctrl_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int NW = 2**AW;

  // FIFO storage holds data only; it is never reset because occupancy is
  // tracked by the pointers and count.
  logic [AW-1:0] r_fifo_addr_p0 [DEPTH];
  logic [DW-1:0] r_fifo_data_p0 [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;

  logic [NW-1:0] r_we_p1;
  logic [DW-1:0] r_wdata_p1;

  logic          w_ack;
  logic          w_push;
  logic          w_pop;
  logic          w_haz;

  // Acceptance depends only on registered occupancy and reset, so there is no
  // combinational path from WR_REQ or the drain side back to WR_ACK.
  assign w_ack  = !RST && (r_count < CW'(DEPTH));
  assign w_push = bus.WR_REQ && w_ack;
  assign w_pop  = !RST && (r_count != '0);

  // ---- stage p0: posted-write FIFO ----
  always_ff @(posedge CLK) begin
    if (w_push) begin
      r_fifo_addr_p0[r_wr_ptr] <= bus.WR_ADDR;
      r_fifo_data_p0[r_wr_ptr] <= bus.WR_DATA;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end

  // ---- stage p1: commit to word registers ----
  // WDATA holds its last value on idle cycles; only WE drops.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_we_p1    <= '0;
      r_wdata_p1 <= '0;
    end else if (w_pop) begin
      r_we_p1    <= NW'(1) << r_fifo_addr_p0[r_rd_ptr];
      r_wdata_p1 <= r_fifo_data_p0[r_rd_ptr];
    end else begin
      r_we_p1    <= '0;
    end
  end

  // Only slots in [rd_ptr, rd_ptr+count) hold live writes; stale slots are
  // masked by comparing the ring offset against the occupancy.
  always_comb begin
    w_haz = r_we_p1[bus.RD_SEL];
    for (int i = 0; i < DEPTH; i++) begin
      if ((CW'(i) < r_count) &&
          (r_fifo_addr_p0[r_rd_ptr + PW'(i)] == bus.RD_SEL)) begin
        w_haz = 1'b1;
      end
    end
  end

  assign bus.WR_ACK = w_ack;
  assign bus.WE     = r_we_p1;
  assign bus.WDATA  = r_wdata_p1;
  assign bus.RD_HAZ = w_haz;
  assign bus.BUSY   = (r_count != '0) || (r_we_p1 != '0);
  assign bus.COUNT  = r_count;
endmodule

// File: tb/tb_data_wr_ctrl.sv
module tb_data_wr_ctrl;
  localparam int DW    = 16;
  localparam int AW    = 4;
  localparam int DEPTH = 4;
  localparam int NW    = 2**AW;

  logic CLK = 1'b0;
  logic RST;
  always #5 CLK = ~CLK;

  data_wr_ctrl_if #(.DW(DW), .AW(AW), .DEPTH(DEPTH)) bus ();

  data_wr_ctrl #(.DW(DW), .AW(AW), .DEPTH(DEPTH)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus.slave)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: queue of pending writes plus the last committed pulse.
  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } wr_t;

  wr_t           q[$];
  logic [NW-1:0] m_we    = '0;
  logic [DW-1:0] m_wdata = '0;

  function automatic logic m_haz(input logic [AW-1:0] sel);
    logic h = m_we[sel];
    foreach (q[i]) if (q[i].a == sel) h = 1'b1;
    return h;
  endfunction

  // Drive one cycle of inputs at the falling edge, advance the model on the
  // rising edge, return at the next falling edge with outputs settled.
  task automatic step(input logic rst, input logic req,
                      input logic [AW-1:0] a, input logic [DW-1:0] d);
    bit acc;
    wr_t h;
    RST         = rst;
    bus.WR_REQ  = req;
    bus.WR_ADDR = a;
    bus.WR_DATA = d;
    acc = !rst && req && (q.size() < DEPTH);
    @(posedge CLK);
    if (rst) begin
      q.delete();
      m_we    = '0;
      m_wdata = '0;
    end else begin
      if (q.size() > 0) begin
        h       = q.pop_front();
        m_we    = NW'(1) << h.a;
        m_wdata = h.d;
      end else begin
        m_we = '0;
      end
      if (acc) q.push_back({a, d});
    end
    @(negedge CLK);
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'($urandom_range(0, 1)), 4'($urandom), 16'($urandom));
      checks++;
      if (bus.WR_ACK !== 1'b0) begin
        errors++; $display("FAIL ack_in_reset got=%b want=0", bus.WR_ACK);
      end
      checks++;
      if (bus.COUNT !== 3'd0 || bus.WE !== 16'h0) begin
        errors++; $display("FAIL state_in_reset count=%0d we=%h want 0/0000", bus.COUNT, bus.WE);
      end
    end
    step(1'b0, 1'b0, '0, '0);
    checks++;
    if (bus.WE !== 16'h0 || bus.WDATA !== 16'h0 || bus.COUNT !== 3'd0) begin
      errors++; $display("FAIL idle_regs we=%h wdata=%h count=%0d want 0000/0000/0", bus.WE, bus.WDATA, bus.COUNT);
    end
    checks++;
    if (bus.WR_ACK !== 1'b1 || bus.BUSY !== 1'b0) begin
      errors++; $display("FAIL idle_status ack=%b busy=%b want 1/0", bus.WR_ACK, bus.BUSY);
    end
    for (int s = 0; s < NW; s++) begin
      bus.RD_SEL = AW'(s);
      #1;
      checks++;
      if (bus.RD_HAZ !== 1'b0) begin
        errors++; $display("FAIL idle_haz sel=%0d got=%b want=0", s, bus.RD_HAZ);
      end
    end
  endtask

  task automatic test_single();
    bus.RD_SEL = 4'd0;
    step(1'b0, 1'b1, 4'd5, 16'hBEEF);
    checks++;
    if (bus.WE !== 16'h0 || bus.COUNT !== 3'd1 || bus.BUSY !== 1'b1) begin
      errors++; $display("FAIL single_queued we=%h count=%0d busy=%b want 0000/1/1", bus.WE, bus.COUNT, bus.BUSY);
    end
    step(1'b0, 1'b0, '0, '0);
    checks++;
    if (bus.WE !== 16'h0020 || bus.WDATA !== 16'hBEEF || bus.COUNT !== 3'd0) begin
      errors++; $display("FAIL single_commit we=%h wdata=%h count=%0d want 0020/beef/0", bus.WE, bus.WDATA, bus.COUNT);
    end
    step(1'b0, 1'b0, '0, '0);
    checks++;
    if (bus.WE !== 16'h0 || bus.BUSY !== 1'b0 || bus.WDATA !== 16'hBEEF) begin
      errors++; $display("FAIL single_after we=%h busy=%b wdata=%h want 0000/0/beef", bus.WE, bus.BUSY, bus.WDATA);
    end
  endtask

  task automatic test_hazard();
    logic exp9 [3] = '{1'b1, 1'b1, 1'b0};
    for (int c = 0; c < 3; c++) begin
      if (c == 0) step(1'b0, 1'b1, 4'd9, 16'($urandom));
      else        step(1'b0, 1'b0, '0, '0);
      bus.RD_SEL = 4'd9;
      #1;
      checks++;
      if (bus.RD_HAZ !== exp9[c]) begin
        errors++; $display("FAIL haz_sel9 cyc=%0d got=%b want=%b", c, bus.RD_HAZ, exp9[c]);
      end
      bus.RD_SEL = 4'd8;
      #1;
      checks++;
      if (bus.RD_HAZ !== 1'b0) begin
        errors++; $display("FAIL haz_sel8 cyc=%0d got=%b want=0", c, bus.RD_HAZ);
      end
    end
  endtask

  task automatic test_same_addr();
    step(1'b0, 1'b1, 4'd3, 16'h1111);
    step(1'b0, 1'b1, 4'd3, 16'h2222);
    checks++;
    if (bus.WE !== 16'h0008 || bus.WDATA !== 16'h1111) begin
      errors++; $display("FAIL same_first we=%h wdata=%h want 0008/1111", bus.WE, bus.WDATA);
    end
    step(1'b0, 1'b0, '0, '0);
    checks++;
    if (bus.WE !== 16'h0008 || bus.WDATA !== 16'h2222) begin
      errors++; $display("FAIL same_second we=%h wdata=%h want 0008/2222", bus.WE, bus.WDATA);
    end
    step(1'b0, 1'b0, '0, '0);
    checks++;
    if (bus.WE !== 16'h0) begin
      errors++; $display("FAIL same_done we=%h want 0000", bus.WE);
    end
  endtask

  task automatic test_back_to_back();
    logic [AW-1:0] sel;
    logic          req;
    for (int i = 0; i < 80; i++) begin
      req = (i < 14) ? 1'b1 : 1'($urandom_range(0, 3) != 0);
      step(1'b0, req, 4'($urandom), 16'($urandom));
      sel = 4'($urandom);
      bus.RD_SEL = sel;
      #1;
      checks++;
      if (bus.WE !== m_we || bus.WDATA !== m_wdata) begin
        errors++; $display("FAIL b2b_commit i=%0d we=%h wdata=%h want %h/%h", i, bus.WE, bus.WDATA, m_we, m_wdata);
      end
      checks++;
      if (bus.COUNT !== 3'(q.size()) || bus.COUNT > 3'(DEPTH)) begin
        errors++; $display("FAIL b2b_count i=%0d got=%0d want=%0d", i, bus.COUNT, q.size());
      end
      checks++;
      if (bus.WR_ACK !== (q.size() < DEPTH) || bus.BUSY !== (q.size() != 0 || m_we != '0)) begin
        errors++; $display("FAIL b2b_status i=%0d ack=%b busy=%b", i, bus.WR_ACK, bus.BUSY);
      end
      checks++;
      if (bus.RD_HAZ !== m_haz(sel)) begin
        errors++; $display("FAIL b2b_haz i=%0d sel=%0d got=%b want=%b", i, sel, bus.RD_HAZ, m_haz(sel));
      end
    end
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, '0, '0);
  endtask

  task automatic test_reset_mid_drain();
    step(1'b0, 1'b1, 4'd1, 16'hA001);
    step(1'b0, 1'b1, 4'd2, 16'hA002);
    step(1'b0, 1'b1, 4'd3, 16'hA003);
    step(1'b1, 1'b1, 4'd4, 16'hA004);
    checks++;
    if (bus.WE !== 16'h0 || bus.COUNT !== 3'd0 || bus.WDATA !== 16'h0) begin
      errors++; $display("FAIL rst_drain_clear we=%h count=%0d wdata=%h want 0000/0/0000", bus.WE, bus.COUNT, bus.WDATA);
    end
    checks++;
    if (bus.WR_ACK !== 1'b0) begin
      errors++; $display("FAIL rst_drain_ack_hi got=%b want=0", bus.WR_ACK);
    end
    RST = 1'b0;
    bus.WR_REQ = 1'b0;
    #1;
    checks++;
    if (bus.WR_ACK !== 1'b1) begin
      errors++; $display("FAIL rst_drain_ack_lo got=%b want=1", bus.WR_ACK);
    end
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, '0, '0);
      checks++;
      if (bus.WE !== 16'h0 || bus.COUNT !== 3'd0 || bus.BUSY !== 1'b0) begin
        errors++; $display("FAIL rst_drain_quiet i=%0d we=%h count=%0d busy=%b", i, bus.WE, bus.COUNT, bus.BUSY);
      end
    end
  endtask

  initial begin
    RST         = 1'b1;
    bus.WR_REQ  = 1'b0;
    bus.WR_ADDR = '0;
    bus.WR_DATA = '0;
    bus.RD_SEL  = '0;
    @(negedge CLK);
    test_reset();
    test_single();
    test_hazard();
    test_same_addr();
    test_back_to_back();
    test_reset_mid_drain();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
